// File: rtl/ysyx_22041752_div_ctrl.sv
// rtl/ysyx_22041752_div_ctrl.sv - issue/retire controller for the iterative RV64M divider
module ysyx_22041752_div_ctrl #(
  parameter int DATA_WD = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req,
  input  logic [2:0]         op,
  input  logic [DATA_WD-1:0] src1,
  input  logic [DATA_WD-1:0] src2,
  output logic               req_ready,
  input  logic               flush,
  input  logic               out_ready,
  output logic               res_valid,
  output logic [DATA_WD-1:0] res_data,
  output logic               div_stall,
  output logic [DATA_WD-1:0] dv_dividend,
  output logic [DATA_WD-1:0] dv_divisor,
  output logic               dv_signed,
  output logic               dv_valid,
  output logic               dv_flush,
  input  logic               dv_out_valid,
  input  logic [DATA_WD-1:0] dv_quotient,
  input  logic [DATA_WD-1:0] dv_remainder
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [2:0]         op_q, op_d;
  logic [DATA_WD-1:0] dividend_q, dividend_d;
  logic [DATA_WD-1:0] divisor_q, divisor_d;
  logic [DATA_WD-1:0] res_q, res_d;
  logic               accept;
  logic               capture;
  logic [DATA_WD-1:0] sel;

  // W variants only look at the low word; signedness picks sign or zero extension.
  function automatic logic [DATA_WD-1:0] prep(input logic [DATA_WD-1:0] v, input logic word,
                                              input logic uns);
    logic [DATA_WD-1:0] r;
    r = v;
    if (word) begin
      r = uns ? {{(DATA_WD-32){1'b0}}, v[31:0]} : {{(DATA_WD-32){v[31]}}, v[31:0]};
    end
    return r;
  endfunction

  assign req_ready = ~flush & ((state_q == IDLE) | ((state_q == DONE) & out_ready));
  assign accept    = req & req_ready;
  assign capture   = (state_q == BUSY) & dv_out_valid & ~flush;
  assign sel       = op_q[1] ? dv_remainder : dv_quotient;

  assign div_stall   = (state_q == BUSY);
  assign dv_valid    = (state_q == BUSY) & ~flush;
  assign dv_flush    = flush;
  assign res_valid   = (state_q == DONE);
  assign res_data    = res_q;
  assign dv_dividend = dividend_q;
  assign dv_divisor  = divisor_q;
  assign dv_signed   = ~op_q[0];

  // Next-state sequencing plus operand latch and result formatting.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    res_d      = res_q;
    case (state_q)
      IDLE: if (accept) state_d = BUSY;
      BUSY: if (dv_out_valid) state_d = DONE;
      DONE: if (out_ready) state_d = accept ? BUSY : IDLE;
      default: state_d = IDLE;
    endcase
    if (accept) begin
      op_d       = op;
      dividend_d = prep(src1, op[2], op[0]);
      divisor_d  = prep(src2, op[2], op[0]);
    end
    if (capture) begin
      res_d = op_q[2] ? {{(DATA_WD-32){sel[31]}}, sel[31:0]} : sel;
    end
    // A flush discards everything in flight, including a result arriving this cycle.
    if (flush) state_d = IDLE;
  end

  // State, operand and result registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      op_q       <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      res_q      <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      res_q      <= res_d;
    end
  end

endmodule

// File: tb/tb_ysyx_22041752_div_ctrl.sv
// tb/tb_ysyx_22041752_div_ctrl.sv - directed bench for ysyx_22041752_div_ctrl
module tb_ysyx_22041752_div_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic [2:0]  op;
  logic [63:0] src1, src2;
  logic        req_ready;
  logic        flush;
  logic        out_ready;
  logic        res_valid;
  logic [63:0] res_data;
  logic        div_stall;
  logic [63:0] dv_dividend, dv_divisor;
  logic        dv_signed, dv_valid, dv_flush;
  logic        dv_out_valid;
  logic [63:0] dv_quotient, dv_remainder;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ysyx_22041752_div_ctrl #(.DATA_WD(64)) dut (
    .clk(clk), .reset(reset), .req(req), .op(op), .src1(src1), .src2(src2),
    .req_ready(req_ready), .flush(flush), .out_ready(out_ready),
    .res_valid(res_valid), .res_data(res_data), .div_stall(div_stall),
    .dv_dividend(dv_dividend), .dv_divisor(dv_divisor), .dv_signed(dv_signed),
    .dv_valid(dv_valid), .dv_flush(dv_flush), .dv_out_valid(dv_out_valid),
    .dv_quotient(dv_quotient), .dv_remainder(dv_remainder)
  );

  // Behavioural divider: 66-cycle iteration, early finish for zero divisor / signed overflow.
  int  cnt;
  logic special;
  always_comb begin
    special = (dv_divisor == 64'd0) ||
              (dv_signed && dv_dividend == 64'h8000_0000_0000_0000 && dv_divisor == '1);
    dv_out_valid = dv_valid && (special || cnt == 65);
    if (dv_divisor == 64'd0) begin
      dv_quotient  = '1;
      dv_remainder = dv_dividend;
    end else if (special) begin
      dv_quotient  = dv_dividend;
      dv_remainder = '0;
    end else if (dv_signed) begin
      dv_quotient  = $signed(dv_dividend) / $signed(dv_divisor);
      dv_remainder = $signed(dv_dividend) % $signed(dv_divisor);
    end else begin
      dv_quotient  = dv_dividend / dv_divisor;
      dv_remainder = dv_dividend % dv_divisor;
    end
  end

  always_ff @(posedge clk) begin
    cnt <= (dv_valid && !dv_out_valid) ? cnt + 1 : 0;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Caller is at a negedge; returns at the negedge of the first DONE cycle.
  task automatic do_op(input string tag, input logic [2:0] o, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] exp_dd,
                       input logic [63:0] exp_ds, input logic [63:0] exp_res,
                       input int exp_lat);
    int lat;
    req = 1'b1; op = o; src1 = a; src2 = b;
    #1;
    chk({tag, "_req_ready"}, {63'd0, req_ready}, 64'd1);
    @(negedge clk);
    req = 1'b0;
    lat = 1;
    chk({tag, "_dv_valid"}, {63'd0, dv_valid}, 64'd1);
    chk({tag, "_div_stall"}, {63'd0, div_stall}, 64'd1);
    chk({tag, "_dividend"}, dv_dividend, exp_dd);
    chk({tag, "_divisor"}, dv_divisor, exp_ds);
    chk({tag, "_signed"}, {63'd0, dv_signed}, {63'd0, ~o[0]});
    while (!res_valid && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_res"}, res_data, exp_res);
  endtask

  logic [63:0] hold;
  bit          seen;

  initial begin
    reset = 1'b0; req = 1'b0; op = '0; src1 = '0; src2 = '0;
    flush = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_res_valid", {63'd0, res_valid}, 64'd0);
    chk("rst_res_data", res_data, 64'd0);
    chk("rst_dv_valid", {63'd0, dv_valid}, 64'd0);
    chk("rst_dividend", dv_dividend, 64'd0);
    chk("rst_req_ready", {63'd0, req_ready}, 64'd1);
    chk("rst_stall", {63'd0, div_stall}, 64'd0);
    reset = 1'b1;
    @(negedge clk);

    do_op("div", 3'b000, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
          64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 67);
    do_op("rem", 3'b010, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
          64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 67);
    do_op("divu0", 3'b001, 64'd5, 64'd0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 2);
    do_op("remu0", 3'b011, 64'd5, 64'd0, 64'd5, 64'd0, 64'd5, 2);
    do_op("divw", 3'b100, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
          64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 67);
    do_op("remw", 3'b110, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
          64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 67);
    do_op("divuw", 3'b101, 64'hFFFF_FFFF_FFFF_FFFE, 64'h0000_0001_0000_0002,
          64'h0000_0000_FFFF_FFFE, 64'd2, 64'h0000_0000_7FFF_FFFF, 67);

    // Flush in the 30th BUSY cycle, with a competing request that must be refused.
    @(negedge clk);
    req = 1'b1; op = 3'b000; src1 = 64'd100; src2 = 64'd7;
    @(negedge clk);
    req = 1'b0;
    repeat (29) @(negedge clk);
    flush = 1'b1; req = 1'b1; op = 3'b001; src1 = 64'd5; src2 = 64'd0;
    #1;
    chk("flush_dv_valid", {63'd0, dv_valid}, 64'd0);
    chk("flush_dv_flush", {63'd0, dv_flush}, 64'd1);
    chk("flush_req_ready", {63'd0, req_ready}, 64'd0);
    @(negedge clk);
    flush = 1'b0; req = 1'b0;
    chk("flush_idle", {63'd0, div_stall}, 64'd0);
    chk("flush_no_res", {63'd0, res_valid}, 64'd0);
    seen = 1'b0;
    repeat (80) begin
      @(negedge clk);
      if (res_valid || dv_valid) seen = 1'b1;
    end
    chk("flush_quiet", {63'd0, seen}, 64'd0);
    do_op("div_after_flush", 3'b000, 64'd100, 64'd7, 64'd100, 64'd7, 64'd14, 67);

    // Back-pressure in DONE, then back-to-back accept on release.
    @(negedge clk);
    out_ready = 1'b0;
    do_op("bp_divu0", 3'b001, 64'd5, 64'd0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 2);
    hold = res_data;
    repeat (10) begin
      @(negedge clk);
      chk("bp_valid", {63'd0, res_valid}, 64'd1);
      chk("bp_stable", res_data, hold);
    end
    req = 1'b1; op = 3'b011; src1 = 64'd5; src2 = 64'd0; out_ready = 1'b1;
    #1;
    chk("b2b_req_ready", {63'd0, req_ready}, 64'd1);
    @(negedge clk);
    req = 1'b0;
    chk("b2b_dv_valid", {63'd0, dv_valid}, 64'd1);
    chk("b2b_res_valid_low", {63'd0, res_valid}, 64'd0);
    @(negedge clk);
    chk("b2b_res_valid", {63'd0, res_valid}, 64'd1);
    chk("b2b_res", res_data, 64'd5);

    // Reset during BUSY returns everything to reset values immediately.
    @(negedge clk);
    req = 1'b1; op = 3'b000; src1 = 64'd100; src2 = 64'd7;
    @(negedge clk);
    req = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mid_rst_dv_valid", {63'd0, dv_valid}, 64'd0);
    chk("mid_rst_stall", {63'd0, div_stall}, 64'd0);
    chk("mid_rst_res", res_data, 64'd0);
    chk("mid_rst_dividend", dv_dividend, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_res_valid", {63'd0, res_valid}, 64'd0);
    chk("post_rst_stall", {63'd0, div_stall}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
